// File: rtl/game_phase_ctrl_pkg.sv
// Shared game constants: phase encoding, BCD digit width, points per match.
// Pure declarations; no timing or flow control involved.
package game_phase_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_READY   = 3'd1,
        ST_PLAY    = 3'd2,
        ST_TIMESUP = 3'd3,
        ST_BOARD   = 3'd4
    } state_t;

    localparam int BCD_W            = 4;
    localparam int POINTS_PER_MATCH = 10;
    // Score is kept in tens, so a match adds this many to the tens digit.
    localparam logic [BCD_W-1:0] TENS_STEP = BCD_W'(POINTS_PER_MATCH / 10);

    // One BCD digit add; result is {carry, digit}.
    function automatic logic [BCD_W:0] bcd_digit_add(
        input logic [BCD_W-1:0] a,
        input logic [BCD_W-1:0] b,
        input logic             cin
    );
        logic [BCD_W:0] sum;
        sum = {1'b0, a} + {1'b0, b} + {{BCD_W{1'b0}}, cin};
        if (sum > (BCD_W+1)'(9))
            return {1'b1, sum[BCD_W-1:0] - BCD_W'(10)};
        return sum;
    endfunction

endpackage

// File: rtl/game_phase_ctrl_bcd_inc_sat.sv
// Three-digit BCD add of TENS_STEP, combinational (zero latency), no flow control.
// An add that would carry out of the top digit returns the input unchanged.
module bcd_inc_sat
    import game_phase_ctrl_pkg::*;
(
    input  logic [3*BCD_W-1:0] digits,
    output logic [3*BCD_W-1:0] digits_inc
);

    logic [BCD_W:0] d0;
    logic [BCD_W:0] d1;
    logic [BCD_W:0] d2;

    always_comb begin
        d0 = bcd_digit_add(digits[BCD_W-1:0], TENS_STEP, 1'b0);
        d1 = bcd_digit_add(digits[2*BCD_W-1:BCD_W], '0, d0[BCD_W]);
        d2 = bcd_digit_add(digits[3*BCD_W-1:2*BCD_W], '0, d1[BCD_W]);
        if (d2[BCD_W])
            digits_inc = digits;
        else
            digits_inc = {d2[BCD_W-1:0], d1[BCD_W-1:0], d0[BCD_W-1:0]};
    end

endmodule

// File: rtl/game_phase_ctrl.sv
// Round sequencer: idle/ready/play/times-up/leaderboard timing, scoring, high score.
// All outputs registered (one cycle after the deciding edge); no backpressure.
module game_phase_ctrl
    import game_phase_ctrl_pkg::*;
#(
    parameter int CLK_HZ    = 25000000,
    parameter int READY_SEC = 3,
    parameter int ROUND_SEC = 30,
    parameter int END_SEC   = 5,
    parameter int BOARD_SEC = 10
) (
    input  logic        iVGA_CLK,
    input  logic        iRST_n,
    input  logic        start_btn,
    input  logic [24:0] ir_in,
    input  logic [24:0] target,
    output logic        get_ready,
    output logic        times_up,
    output logic        leaderboard,
    output logic        in_play,
    output logic        clear_trace,
    output logic [15:0] score_bcd,
    output logic [15:0] hi_score_bcd,
    output logic [5:0]  seconds_left
);

    localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

    state_t          state;
    state_t          next_state;
    logic [PW-1:0]   presc;
    logic            sec_tick;
    logic            phase_end;
    logic            state_chg;
    logic            start_q;
    logic            start_rise;
    logic            match_q;
    logic            match_d;
    logic            score_evt;
    logic            play_entry;
    logic [5:0]      secs_load;
    logic [11:0]     score_inc;

    assign sec_tick   = (presc == PW'(CLK_HZ - 1));
    assign phase_end  = sec_tick && (seconds_left == 6'd1);
    assign start_rise = start_btn && !start_q;
    assign state_chg  = (next_state != state);
    assign play_entry = (next_state == ST_PLAY) && (state != ST_PLAY);
    // A match landing on the final play tick is dropped with the round.
    assign score_evt  = (state == ST_PLAY) && match_q && !match_d && !phase_end;

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:    if (start_rise) next_state = ST_READY;
            ST_READY:   if (phase_end)  next_state = ST_PLAY;
            ST_PLAY:    if (phase_end)  next_state = ST_TIMESUP;
            ST_TIMESUP: if (phase_end)  next_state = ST_BOARD;
            ST_BOARD:   if (phase_end)  next_state = ST_IDLE;
            default:                    next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        secs_load = '0;
        case (next_state)
            ST_READY:   secs_load = 6'(READY_SEC);
            ST_PLAY:    secs_load = 6'(ROUND_SEC);
            ST_TIMESUP: secs_load = 6'(END_SEC);
            ST_BOARD:   secs_load = 6'(BOARD_SEC);
            default:    secs_load = '0;
        endcase
    end

    bcd_inc_sat u_bcd_inc_sat (
        .digits     (score_bcd[15:4]),
        .digits_inc (score_inc)
    );

    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state        <= ST_IDLE;
            presc        <= '0;
            seconds_left <= '0;
            start_q      <= 1'b0;
            match_q      <= 1'b0;
            match_d      <= 1'b0;
            get_ready    <= 1'b0;
            in_play      <= 1'b0;
            times_up     <= 1'b0;
            leaderboard  <= 1'b0;
            clear_trace  <= 1'b0;
            score_bcd    <= '0;
            hi_score_bcd <= '0;
        end else begin
            state   <= next_state;
            start_q <= start_btn;

            // Prescaler restarts on every phase change so each phase gets whole seconds.
            if (state_chg || sec_tick)
                presc <= '0;
            else
                presc <= presc + PW'(1);

            if (state_chg)
                seconds_left <= secs_load;
            else if (state == ST_IDLE)
                seconds_left <= '0;
            else if (sec_tick && seconds_left != 6'd0)
                seconds_left <= seconds_left - 6'd1;

            get_ready   <= (next_state == ST_READY);
            in_play     <= (next_state == ST_PLAY);
            times_up    <= (next_state == ST_TIMESUP);
            leaderboard <= (next_state == ST_BOARD);

            match_q     <= (state == ST_PLAY) && (ir_in == target) && (target != '0);
            match_d     <= match_q;
            clear_trace <= play_entry || score_evt;

            if (state == ST_IDLE && next_state == ST_READY)
                score_bcd <= '0;
            else if (score_evt)
                score_bcd <= {score_inc, 4'h0};

            if (state == ST_TIMESUP && next_state == ST_BOARD && score_bcd > hi_score_bcd)
                hi_score_bcd <= score_bcd;
        end
    end

endmodule
